// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file host-access controller:
// FSM state encoding, host command codes and register-file geometry.
package regfile_ctrl_pkg;

    localparam int RF_DW    = 32;
    localparam int RF_AW    = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_READ  = 2'b00,
        CMD_WRITE = 2'b01,
        CMD_DUMP  = 2'b10,
        CMD_RSVD  = 2'b11
    } host_cmd_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Host/debug access controller for the register file. Shares the write port
// and read port A between the core and the host: stalls the core, performs a
// single read or write, or streams every register out over a valid/ready
// dump channel. The register file itself lives in the parent.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          cpu_werf,
    input  logic [AW-1:0] cpu_wa,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [AW-1:0] cpu_ra,
    output logic          cpu_stall,
    // register-file ports
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_ra,
    input  logic [DW-1:0] rf_radata,
    // host side
    input  logic          host_req,
    input  logic [1:0]    host_cmd,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic          busy,
    // dump channel
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_idx,
    output logic [DW-1:0] dump_data,
    output logic          dump_last
);

    // Highest index is the hard-wired zero register; it also ends a dump.
    localparam logic [AW-1:0] TOP_IDX = '1;

    state_t        state, state_nxt;
    host_cmd_t     cmd_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [AW-1:0] idx_q;

    logic          dump_hs;
    assign dump_hs = (state == ST_DUMP_OUT) && dump_ready;

    // State register; reset aborts any operation without an acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (host_req) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                case (cmd_q)
                    CMD_READ, CMD_WRITE: state_nxt = ST_ACCESS;
                    CMD_DUMP:            state_nxt = ST_DUMP_RD;
                    default:             state_nxt = ST_DONE;
                endcase
            end
            ST_ACCESS:   state_nxt = ST_DONE;
            ST_DUMP_RD:  state_nxt = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (dump_ready) state_nxt = dump_last ? ST_DONE : ST_DUMP_RD;
            end
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: core passthrough in IDLE, host-owned ports elsewhere.
    always_comb begin
        rf_we      = 1'b0;
        rf_wa      = addr_q;
        rf_wdata   = wdata_q;
        rf_ra      = cpu_ra;
        cpu_stall  = 1'b1;
        busy       = 1'b1;
        host_ack   = 1'b0;
        dump_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                rf_we     = cpu_werf;
                rf_wa     = cpu_wa;
                rf_wdata  = cpu_wdata;
                cpu_stall = 1'b0;
                busy      = 1'b0;
            end
            ST_ACCESS: begin
                // Writes to the zero register are dropped silently.
                rf_we = (cmd_q == CMD_WRITE) && (addr_q != TOP_IDX);
                rf_ra = addr_q;
            end
            ST_DUMP_RD:  rf_ra      = idx_q;
            ST_DUMP_OUT: dump_valid = 1'b1;
            ST_DONE:     host_ack   = 1'b1;
            default: ;
        endcase
    end

    // Request latches, captured when the request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == ST_IDLE && host_req) begin
            cmd_q   <= host_cmd_t'(host_cmd);
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
        end
    end

    // Host read result, held until the next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            host_rdata <= '0;
        else if (state == ST_ACCESS && cmd_q == CMD_READ)
            host_rdata <= rf_radata;
    end

    // Dump index: cleared on each new request, advanced on every non-final
    // handshake. The final beat ends the dump, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idx_q <= '0;
        else if (state == ST_IDLE && host_req)
            idx_q <= '0;
        else if (dump_hs && !dump_last)
            idx_q <= idx_q + 1'b1;
    end

    // Dump beat registers, loaded in DUMP_RD and held through DUMP_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_data <= '0;
            dump_idx  <= '0;
            dump_last <= 1'b0;
        end else if (state == ST_DUMP_RD) begin
            dump_data <= rf_radata;
            dump_idx  <= idx_q;
            dump_last <= (idx_q == TOP_IDX);
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl: directed vector table,
// hand-written dump/reset sequences and randomized host/core traffic checked
// against a shadow register model.
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

    logic        clk, rst_n;
    logic        cpu_werf;
    logic [4:0]  cpu_wa, cpu_ra;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        rf_we;
    logic [4:0]  rf_wa, rf_ra;
    logic [31:0] rf_wdata, rf_radata;
    logic        host_req;
    logic [1:0]  host_cmd;
    logic [4:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        busy;
    logic        dump_valid, dump_ready, dump_last;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;

    regfile_access_ctrl #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_werf(cpu_werf), .cpu_wa(cpu_wa), .cpu_wdata(cpu_wdata),
        .cpu_ra(cpu_ra), .cpu_stall(cpu_stall),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .rf_ra(rf_ra), .rf_radata(rf_radata),
        .host_req(host_req), .host_cmd(host_cmd), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .dump_last(dump_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file owned by the parent: async read, R31 reads zero.
    logic [31:0] mem [32];
    assign rf_radata = (rf_ra == 5'd31) ? 32'h0 : mem[rf_ra];
    always @(posedge clk) if (rf_we && rf_wa != 5'd31) mem[rf_wa] <= rf_wdata;

    // Reference model: architectural register contents and last read result.
    logic [31:0] shadow [32];
    logic [31:0] last_rd;

    int checks = 0;
    int failures = 0;

    logic [4:0]  bq_idx  [$];
    logic [31:0] bq_data [$];
    logic        bq_last [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic shadow_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        if (en && a != 5'd31) shadow[a] = d;
    endtask

    // One host transaction. rmode: 0 ready high, 1 ready 1-0-0-1, 2 random.
    // cw_* is a core write presented in the request cycle; noise keeps the
    // core writing garbage to cw_wa for the whole stall.
    task automatic host_op(input logic [1:0] cmd, input logic [4:0] addr,
                           input logic [31:0] wd, input int rmode,
                           input logic cw_en, input logic [4:0] cw_wa,
                           input logic [31:0] cw_wd, input logic noise,
                           output int ack_cyc, output int we_cnt,
                           output int stall_cnt, output logic [31:0] rd);
        logic        pv, pr, r;
        logic [4:0]  pidx;
        logic [31:0] pdata;
        bq_idx.delete(); bq_data.delete(); bq_last.delete();
        @(negedge clk);
        host_req = 1'b1; host_cmd = cmd; host_addr = addr; host_wdata = wd;
        cpu_werf = cw_en; cpu_wa = cw_wa; cpu_wdata = cw_wd;
        dump_ready = (rmode == 0);
        @(posedge clk);
        ack_cyc = 0; we_cnt = 0; stall_cnt = 0; rd = '0;
        pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0;
        for (int c = 1; c <= 400 && ack_cyc == 0; c++) begin
            #1;
            cpu_werf  = noise;
            cpu_wa    = cw_wa;
            cpu_wdata = $urandom;
            if (cpu_stall) stall_cnt++;
            if (rf_we) we_cnt++;
            if (pv && !pr) begin
                chk("dump_hold_valid", {31'b0, dump_valid}, 32'd1);
                chk("dump_hold_idx", {27'b0, dump_idx}, {27'b0, pidx});
                chk("dump_hold_data", dump_data, pdata);
            end
            case (rmode)
                0:       r = 1'b1;
                1:       r = (c % 4 == 0) || (c % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            dump_ready = r;
            if (dump_valid && r) begin
                bq_idx.push_back(dump_idx);
                bq_data.push_back(dump_data);
                bq_last.push_back(dump_last);
            end
            pv = dump_valid; pr = r; pidx = dump_idx; pdata = dump_data;
            if (host_ack) begin
                ack_cyc = c; rd = host_rdata;
                host_req = 1'b0; cpu_werf = 1'b0; dump_ready = 1'b0;
            end else begin
                @(posedge clk);
            end
        end
        if (ack_cyc == 0) begin
            failures++; checks++;
            $display("FAIL host_op_timeout: no ACK within 400 cycles for cmd %0d", cmd);
            host_req = 1'b0; cpu_werf = 1'b0;
        end
        @(posedge clk); #1;
        chk("post_ack_stall", {31'b0, cpu_stall}, 32'd0);
        chk("post_ack_busy", {31'b0, busy}, 32'd0);
        chk("ack_one_pulse", {31'b0, host_ack}, 32'd0);
    endtask

    task automatic check_dump(input string tag);
        chk({tag, "_beats"}, bq_idx.size(), 32'd32);
        for (int i = 0; i < bq_idx.size() && i < 32; i++) begin
            chk({tag, "_idx"}, {27'b0, bq_idx[i]}, i);
            chk({tag, "_data"}, bq_data[i], (i == 31) ? 32'h0 : shadow[i]);
            chk({tag, "_last"}, {31'b0, bq_last[i]}, (i == 31) ? 32'd1 : 32'd0);
        end
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_ack;
        int          exp_we;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack, we, st, nack;
        logic [31:0] rd;
        logic found;

        for (int i = 0; i < 32; i++) begin mem[i] = '0; shadow[i] = '0; end
        last_rd = '0;
        rst_n = 1'b0; host_req = 1'b0; host_cmd = '0; host_addr = '0; host_wdata = '0;
        cpu_werf = 1'b0; cpu_wa = '0; cpu_wdata = '0; cpu_ra = 5'd7; dump_ready = 1'b0;

        // Reset values and IDLE passthrough.
        #1;
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ack", {31'b0, host_ack}, 32'd0);
        chk("rst_dvalid", {31'b0, dump_valid}, 32'd0);
        chk("rst_dlast", {31'b0, dump_last}, 32'd0);
        chk("rst_rdata", host_rdata, 32'd0);
        chk("rst_ddata", dump_data, 32'd0);
        chk("rst_didx", {27'b0, dump_idx}, 32'd0);
        chk("rst_rf_ra", {27'b0, rf_ra}, 32'd7);
        cpu_werf = 1'b1; cpu_wa = 5'd4; cpu_wdata = 32'hCAFE0004;
        #1;
        chk("rst_rf_we", {31'b0, rf_we}, 32'd1);
        chk("rst_rf_wa", {27'b0, rf_wa}, 32'd4);
        chk("rst_rf_wdata", rf_wdata, 32'hCAFE0004);
        cpu_werf = 1'b0;
        @(posedge clk); @(negedge clk); rst_n = 1'b1;

        // Directed single-access vectors.
        vecs[0] = '{CMD_WRITE, 5'd5,  32'hDEADBEEF, 32'h0,        3, 1};
        vecs[1] = '{CMD_READ,  5'd5,  32'h0,        32'hDEADBEEF, 3, 0};
        vecs[2] = '{CMD_WRITE, 5'd31, 32'h1234,     32'hDEADBEEF, 3, 0};
        vecs[3] = '{CMD_READ,  5'd31, 32'h0,        32'h0,        3, 0};
        vecs[4] = '{CMD_RSVD,  5'd5,  32'h77,       32'h0,        2, 0};
        vecs[5] = '{CMD_WRITE, 5'd0,  32'hA5A5A5A5, 32'h0,        3, 1};
        vecs[6] = '{CMD_READ,  5'd0,  32'h0,        32'hA5A5A5A5, 3, 0};
        vecs[7] = '{CMD_RSVD,  5'd0,  32'h0,        32'hA5A5A5A5, 2, 0};
        foreach (vecs[i]) begin
            host_op(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, 0, 1'b0, 5'd0, 32'h0, 1'b0,
                    ack, we, st, rd);
            chk("vec_ack_cycle", ack, vecs[i].exp_ack);
            chk("vec_stall_cycles", st, vecs[i].exp_ack);
            chk("vec_rf_we_cycles", we, vecs[i].exp_we);
            chk("vec_rdata", rd, vecs[i].exp_rd);
            if (vecs[i].cmd == CMD_WRITE) shadow_write(1'b1, vecs[i].addr, vecs[i].wdata);
        end
        last_rd = 32'hA5A5A5A5;

        // Preload Rn = n*0x11, then dump with READY high.
        for (int n = 0; n < 32; n++) begin
            host_op(CMD_WRITE, 5'(n), 32'(n * 32'h11), 0, 1'b0, 5'd0, 32'h0, 1'b0, ack, we, st, rd);
            shadow_write(1'b1, 5'(n), 32'(n * 32'h11));
        end
        host_op(CMD_DUMP, 5'd0, 32'h0, 0, 1'b0, 5'd0, 32'h0, 1'b0, ack, we, st, rd);
        check_dump("dump_fast");
        chk("dump_fast_stall", st, 32'd66);
        chk("dump_fast_ack", ack, 32'd66);
        chk("dump_fast_we", we, 32'd0);
        chk("dump_fast_rdata", rd, last_rd);

        // Dump under 1-0-0-1 backpressure.
        host_op(CMD_DUMP, 5'd0, 32'h0, 1, 1'b0, 5'd0, 32'h0, 1'b0, ack, we, st, rd);
        check_dump("dump_bp");
        chk("dump_bp_rdata", rd, last_rd);

        // Core writes R3 every cycle across a host read of R3.
        host_op(CMD_READ, 5'd3, 32'h0, 0, 1'b1, 5'd3, 32'h55, 1'b1, ack, we, st, rd);
        shadow_write(1'b1, 5'd3, 32'h55);
        last_rd = 32'h55;
        chk("corewr_ack", ack, 32'd3);
        chk("corewr_rdata", rd, 32'h55);
        chk("corewr_mem_r3", mem[3], 32'h55);

        // Randomized traffic against the shadow model.
        for (int k = 0; k < 40; k++) begin
            int          sel, gap, rm;
            logic [1:0]  cmd;
            logic [4:0]  a, cwa;
            logic [31:0] d, cwd;
            logic        cwe;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(negedge clk);
                cpu_werf = 1'($urandom_range(0, 1)); cpu_wa = 5'($urandom); cpu_wdata = $urandom;
                @(posedge clk);
                shadow_write(cpu_werf, cpu_wa, cpu_wdata);
            end
            sel = $urandom_range(0, 9);
            cmd = (sel < 4) ? CMD_READ : (sel < 8) ? CMD_WRITE : (sel == 8) ? CMD_RSVD : CMD_DUMP;
            a = 5'($urandom); d = $urandom;
            cwe = 1'($urandom_range(0, 1)); cwa = 5'($urandom); cwd = $urandom;
            rm = (cmd == CMD_DUMP) ? 2 : 0;
            host_op(cmd, a, d, rm, cwe, cwa, cwd, 1'b1, ack, we, st, rd);
            shadow_write(cwe, cwa, cwd);
            case (cmd)
                CMD_READ: begin
                    last_rd = (a == 5'd31) ? 32'h0 : shadow[a];
                    chk("rnd_read_ack", ack, 32'd3);
                    chk("rnd_read_data", rd, last_rd);
                end
                CMD_WRITE: begin
                    chk("rnd_write_ack", ack, 32'd3);
                    chk("rnd_write_we", we, (a == 5'd31) ? 32'd0 : 32'd1);
                    chk("rnd_write_rdata", rd, last_rd);
                    shadow_write(1'b1, a, d);
                end
                CMD_RSVD: begin
                    chk("rnd_rsvd_ack", ack, 32'd2);
                    chk("rnd_rsvd_we", we, 32'd0);
                    chk("rnd_rsvd_rdata", rd, last_rd);
                end
                default: begin
                    check_dump("rnd_dump");
                    chk("rnd_dump_rdata", rd, last_rd);
                end
            endcase
        end

        // Reset pulse during dump beat 10.
        @(negedge clk);
        host_req = 1'b1; host_cmd = CMD_DUMP; host_addr = '0; dump_ready = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            #1;
            if (dump_valid && dump_idx == 5'd10) found = 1'b1;
            else @(posedge clk);
        end
        chk("rstdump_reached_beat10", {31'b0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        host_req = 1'b0; dump_ready = 1'b0;
        chk("rstdump_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rstdump_busy", {31'b0, busy}, 32'd0);
        chk("rstdump_valid", {31'b0, dump_valid}, 32'd0);
        chk("rstdump_idx", {27'b0, dump_idx}, 32'd0);
        chk("rstdump_data", dump_data, 32'd0);
        chk("rstdump_last", {31'b0, dump_last}, 32'd0);
        chk("rstdump_rdata", host_rdata, 32'd0);
        last_rd = '0;
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        nack = 0;
        repeat (5) begin @(posedge clk); #1; if (host_ack) nack++; end
        chk("rstdump_no_ack", nack, 32'd0);
        host_op(CMD_READ, 5'd5, 32'h0, 0, 1'b0, 5'd0, 32'h0, 1'b0, ack, we, st, rd);
        chk("rstdump_read_ack", ack, 32'd3);
        chk("rstdump_read_data", rd, shadow[5]);

        // Final register-file contents against the model.
        for (int i = 0; i < 31; i++) chk("final_mem", mem[i], shadow[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
